fib_filter_accum: RTL and testbench

//   Clocked Fibonacci accumulator. Generates the sequence 1, 2, 3, 5, ... one

---
 rtl/fib_filter_accum_if.sv | 26 ++
 rtl/fib_filter_accum.sv | 120 ++++++++++++
 tb/tb_fib_filter_accum.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_filter_accum_if.sv
// Start/done bus shared by the numeric-engine solvers: request fields in,
// status and results out.
interface fib_filter_accum_if #(
  parameter int W     = 32,
  parameter int SUM_W = 32,
  parameter int CNT_W = 8
);
  logic             start;
  logic [W-1:0]     limit;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] count;
  logic [1:0]       ovf;

  modport master (
    output start, limit, mode,
    input  busy, done, sum, count, ovf
  );

  modport slave (
    input  start, limit, mode,
    output busy, done, sum, count, ovf
  );
endinterface

// File: rtl/fib_filter_accum.sv
// Fibonacci accumulator: walks 1, 2, 3, 5, ... one term per cycle and sums
// the terms up to a limit that pass an even/odd/all filter, saturating.
module fib_filter_accum #(
  parameter int W     = 32,
  parameter int SUM_W = 32,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fib_filter_accum_if.slave bus
);

  generate
    if (SUM_W < W) begin : g_cfg_err
      $error("fib_filter_accum: SUM_W must be at least W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             bov_q;
  logic [W-1:0]     limit_q;
  logic [1:0]       mode_q;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             sel_d;
  logic [SUM_W:0]   sum_add_d;
  logic [W:0]       fib_add_d;

  always_comb begin
    sel_d     = mode_q[1] | (a_q[0] == mode_q[0]);
    sum_add_d = {1'b0, sum_q} + (SUM_W + 1)'(a_q);
    fib_add_d = {1'b0, a_q} + {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= W'(1);
      b_q     <= W'(2);
      bov_q   <= 1'b0;
      limit_q <= '0;
      mode_q  <= 2'b00;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            limit_q <= bus.limit;
            mode_q  <= bus.mode;
            a_q     <= W'(1);
            b_q     <= W'(2);
            bov_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 2'b00;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (a_q > limit_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            if (sel_d) begin
              if (sum_add_d[SUM_W]) begin
                sum_q    <= '1;
                ovf_q[0] <= 1'b1;
              end else begin
                sum_q <= sum_add_d[SUM_W-1:0];
              end
              if (count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
              end
            end
            a_q   <= b_q;
            b_q   <= fib_add_d[W-1:0];
            bov_q <= fib_add_d[W];
            // a_q here is the last representable term; stop after taking it.
            if (bov_q) begin
              ovf_q[1] <= 1'b1;
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_fib_filter_accum.sv
// Scoreboard bench: expected results queued at start, checked on each done
// pulse of the 32-bit instance; a narrow 8-bit instance covers overflow.
module tb_fib_filter_accum;

  typedef struct {
    longint sum;
    int     count;
    int     ovf;
    int     cycles;
  } exp_t;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  exp_t sb[$];
  exp_t last_exp;
  logic have_result;
  int   busy_cnt;
  logic prev_done;

  fib_filter_accum_if #(.W(32), .SUM_W(32), .CNT_W(8)) if32 ();
  fib_filter_accum_if #(.W(8),  .SUM_W(8),  .CNT_W(8)) if8 ();

  fib_filter_accum #(.W(32), .SUM_W(32), .CNT_W(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  fib_filter_accum #(.W(8), .SUM_W(8), .CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint lim, input logic [1:0] m,
                                 input int w, input int sw, input int cw);
    exp_t   r;
    longint wmax, smax, cmax, a, b, nb, s;
    logic   bov, nbov, sel;
    wmax = (64'd1 << w) - 1;
    smax = (64'd1 << sw) - 1;
    cmax = (64'd1 << cw) - 1;
    a = 1; b = 2; bov = 1'b0;
    r.sum = 0; r.count = 0; r.ovf = 0; r.cycles = 0;
    while (1) begin
      r.cycles++;
      if (a > lim) break;
      sel = m[1] || (a[0] == m[0]);
      if (sel) begin
        s = r.sum + a;
        if (s > smax) begin
          s = smax;
          r.ovf = r.ovf | 1;
        end
        r.sum = s;
        if (r.count < cmax) r.count++;
      end
      if (bov) begin
        r.ovf = r.ovf | 2;
        break;
      end
      nb   = a + b;
      nbov = (nb > wmax);
      a    = b;
      b    = nb & wmax;
      bov  = nbov;
    end
    return r;
  endfunction

  // Result and handshake checks on the 32-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt    = 0;
      have_result = 1'b0;
      prev_done   = 1'b0;
    end else begin
      if (prev_done) check_val("done_pulse", longint'(if32.done), 0);
      if (if32.done) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("run done: sum=%0d count=%0d ovf=%0d cycles=%0d (exp %0d/%0d/%0d/%0d)",
                   if32.sum, if32.count, if32.ovf, busy_cnt, e.sum, e.count, e.ovf, e.cycles);
          check_val("sum",    longint'(if32.sum),   e.sum);
          check_val("count",  longint'(if32.count), longint'(e.count));
          check_val("ovf",    longint'(if32.ovf),   longint'(e.ovf));
          check_val("cycles", longint'(busy_cnt),   longint'(e.cycles));
          check_val("busy_at_done", longint'(if32.busy), 0);
          last_exp    = e;
          have_result = 1'b1;
        end
        busy_cnt = 0;
      end else if (if32.busy) begin
        busy_cnt++;
        have_result = 1'b0;
      end else if (have_result) begin
        check_val("sum_held", longint'(if32.sum), last_exp.sum);
      end
      prev_done = if32.done;
    end
  end

  // Drives one start cycle; caller positions the call on a falling edge.
  task automatic run32(input logic [31:0] lim, input logic [1:0] m, input exp_t e);
    if32.limit = lim;
    if32.mode  = m;
    if32.start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 if32.start = 1'b0;
  endtask

  task automatic run32_model(input logic [31:0] lim, input logic [1:0] m);
    run32(lim, m, model(longint'(lim), m, 32, 32, 8));
  endtask

  task automatic wait_done32(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if32.done && n < budget);
    if (!if32.done) check_val("timeout32", 0, 1);
  endtask

  function automatic exp_t mk(input longint s, input int c, input int o, input int cyc);
    exp_t e;
    e.sum = s; e.count = c; e.ovf = o; e.cycles = cyc;
    return e;
  endfunction

  initial begin
    int cyc8;
    logic [31:0] rl;
    logic [1:0]  rm;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    if32.start = 1'b0; if32.limit = '0; if32.mode = 2'b00;
    if8.start  = 1'b0; if8.limit  = '0; if8.mode  = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy",  longint'(if32.busy),  0);
    check_val("rst_done",  longint'(if32.done),  0);
    check_val("rst_sum",   longint'(if32.sum),   0);
    check_val("rst_count", longint'(if32.count), 0);
    check_val("rst_ovf",   longint'(if32.ovf),   0);
    check_val("rst8_sum",  longint'(if8.sum),    0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run32(32'd4000000, 2'b00, mk(4613732, 11, 0, 33));
    wait_done32(200);
    @(negedge clk);
    run32(32'd10, 2'b00, mk(10, 2, 0, 6));
    wait_done32(50);
    @(negedge clk);
    run32(32'd10, 2'b01, mk(9, 3, 0, 6));
    wait_done32(50);
    @(negedge clk);
    run32(32'd10, 2'b10, mk(19, 5, 0, 6));
    wait_done32(50);
    @(negedge clk);
    run32(32'd0, 2'b10, mk(0, 0, 0, 1));
    wait_done32(50);
    @(negedge clk);

    // Start pulsed mid-run must not disturb the run in progress
    run32_model(32'd1000, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    if32.limit = 32'd5; if32.mode = 2'b00; if32.start = 1'b1;
    @(posedge clk);
    #1 if32.start = 1'b0;
    wait_done32(100);

    // Back-to-back: start raised during the done cycle
    run32(32'd10, 2'b00, mk(10, 2, 0, 6));
    wait_done32(50);
    @(negedge clk);

    // Reset mid-run abandons the run
    run32(32'd1000000, 2'b10, mk(0, 0, 0, 0));
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_busy",  longint'(if32.busy),  0);
    check_val("midrst_sum",   longint'(if32.sum),   0);
    check_val("midrst_count", longint'(if32.count), 0);
    check_val("midrst_ovf",   longint'(if32.ovf),   0);
    $display("mid-run reset: busy=%0d sum=%0d count=%0d", if32.busy, if32.sum, if32.count);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run32(32'd10, 2'b10, mk(19, 5, 0, 6));
    wait_done32(50);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      rl = $urandom_range(0, 200000);
      rm = 2'($urandom_range(0, 3));
      run32_model(rl, rm);
      wait_done32(100);
      @(negedge clk);
    end

    // Narrow instance: sequence outgrows 8 bits and the sum saturates
    if8.limit = 8'd255; if8.mode = 2'b10; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    cyc8 = 0;
    do begin
      @(negedge clk);
      if (if8.busy) cyc8++;
    end while (!if8.done && cyc8 < 100);
    $display("w8 run: sum=%0d count=%0d ovf=%0d cycles=%0d", if8.sum, if8.count, if8.ovf, cyc8);
    check_val("w8_done",   longint'(if8.done),  1);
    check_val("w8_sum",    longint'(if8.sum),   255);
    check_val("w8_count",  longint'(if8.count), 12);
    check_val("w8_ovf",    longint'(if8.ovf),   3);
    check_val("w8_cycles", longint'(cyc8),      12);

    @(negedge clk);
    check_val("sb_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
